// File: rtl/vector_write_sequencer.sv
// Scalar or strided-vector store sequencer with a start/busy/done handshake and mem_ready stall.
// Define VWS_MASK_EN to add a per-item write mask; the default build has no mask port.
module vector_write_sequencer #(
    parameter int I  = 20,
    parameter int L  = 32,
    parameter int A  = 10,
    parameter int CW = $clog2(I + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_type,
    input  logic [I*L-1:0]   vector_data,
    input  logic [L-1:0]     scalar_data,
    input  logic [A-1:0]     base_address,
    input  logic [A-1:0]     stride,
    input  logic [CW-1:0]    vlen,
`ifdef VWS_MASK_EN
    input  logic [I-1:0]     mask,
`endif
    input  logic             mem_ready,
    output logic             write_en,
    output logic [A-1:0]     write_address,
    output logic [L-1:0]     write_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   index_q, index_d;
    logic [CW-1:0]   count_q, count_d;
    logic            op_q, op_d;
    logic [I*L-1:0]  vdata_q, vdata_d;
    logic [L-1:0]    sdata_q, sdata_d;
    logic [A-1:0]    addr_q, addr_d;
    logic [A-1:0]    stride_q, stride_d;
    logic            item_en;
    logic            advance;
    logic            last;

`ifdef VWS_MASK_EN
    logic [I-1:0]    mask_q, mask_d;

    // A masked-off vector item still spends a cycle, but never waits on memory.
    assign item_en = !op_q || mask_q[index_q];
`else
    assign item_en = 1'b1;
`endif

    assign advance = (state_q == WRITE) && (!item_en || mem_ready);
    assign last    = (index_q == count_q - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            index_q  <= '0;
            count_q  <= '0;
            op_q     <= 1'b0;
            vdata_q  <= '0;
            sdata_q  <= '0;
            addr_q   <= '0;
            stride_q <= '0;
`ifdef VWS_MASK_EN
            mask_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            count_q  <= count_d;
            op_q     <= op_d;
            vdata_q  <= vdata_d;
            sdata_q  <= sdata_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
`ifdef VWS_MASK_EN
            mask_q   <= mask_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        count_d  = count_q;
        op_d     = op_q;
        vdata_d  = vdata_q;
        sdata_d  = sdata_q;
        addr_d   = addr_q;
        stride_d = stride_q;
`ifdef VWS_MASK_EN
        mask_d   = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op_type;
                    vdata_d  = vector_data;
                    sdata_d  = scalar_data;
                    stride_d = stride;
                    addr_d   = base_address;
                    index_d  = '0;
`ifdef VWS_MASK_EN
                    mask_d   = mask;
`endif
                    // Oversized vector lengths are silently clamped to the item capacity.
                    if (!op_type) begin
                        count_d = CW'(1);
                    end else if (vlen > CW'(I)) begin
                        count_d = CW'(I);
                    end else begin
                        count_d = vlen;
                    end
                    state_d = (op_type && (vlen == '0)) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (advance) begin
                    index_d = index_q + 1'b1;
                    addr_d  = addr_q + stride_q;
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        write_en      = 1'b0;
        write_address = '0;
        write_data    = '0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            WRITE: begin
                write_en      = item_en;
                busy          = 1'b1;
                write_address = addr_q;
                write_data    = op_q ? vdata_q[int'(index_q)*L +: L] : sdata_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vector_write_sequencer.sv
// Scoreboard bench for vector_write_sequencer: expected writes are queued when a store is
// started and matched against accepted writes; define VWS_MASK_EN to include the mask scenario.
module tb_vector_write_sequencer;

    localparam int I  = 20;
    localparam int L  = 32;
    localparam int A  = 10;
    localparam int CW = $clog2(I + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            op_type;
    logic [I*L-1:0]  vector_data;
    logic [L-1:0]    scalar_data;
    logic [A-1:0]    base_address;
    logic [A-1:0]    stride;
    logic [CW-1:0]   vlen;
    logic            mem_ready;
    logic            write_en;
    logic [A-1:0]    write_address;
    logic [L-1:0]    write_data;
    logic            busy;
    logic            done;
`ifdef VWS_MASK_EN
    logic [I-1:0]    mask;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [A-1:0] exp_addr[$];
    logic [L-1:0] exp_data[$];
    logic [A-1:0] obs_addr[$];
    logic [L-1:0] obs_data[$];

    always #5 clk = ~clk;

    vector_write_sequencer #(.I(I), .L(L), .A(A), .CW(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .op_type       (op_type),
        .vector_data   (vector_data),
        .scalar_data   (scalar_data),
        .base_address  (base_address),
        .stride        (stride),
        .vlen          (vlen),
`ifdef VWS_MASK_EN
        .mask          (mask),
`endif
        .mem_ready     (mem_ready),
        .write_en      (write_en),
        .write_address (write_address),
        .write_data    (write_data),
        .busy          (busy),
        .done          (done)
    );

    // Presents a request during one cycle; the rising edge that follows is edge 0.
    task automatic drive_start(input logic op, input logic [A-1:0] base,
                               input logic [A-1:0] strd, input logic [CW-1:0] vl);
        @(negedge clk);
        op_type      = op;
        base_address = base;
        stride       = strd;
        vlen         = vl;
        mem_ready    = 1'b1;
        start        = 1'b1;
        @(posedge clk);
    endtask

    // Observes cycles 1..budget at mid-cycle, recording accepted writes; stops on done.
    task automatic collect(input int budget, input int stall_lo, input int stall_hi,
                           input logic keep_start, input logic scramble,
                           output int done_cycle, output int en_cycles);
        done_cycle = 0;
        en_cycles  = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start     = keep_start;
            mem_ready = !((c >= stall_lo) && (c <= stall_hi));
            if (scramble) begin
                for (int k = 0; k < I; k++) vector_data[k*L +: L] = $urandom;
                scalar_data  = $urandom;
                base_address = A'($urandom);
                stride       = A'($urandom);
            end
            if (write_en) begin
                en_cycles++;
                if (mem_ready) begin
                    obs_addr.push_back(write_address);
                    obs_data.push_back(write_data);
                end
            end
            if (done) begin
                done_cycle = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({write_en, busy, done, write_address, write_data} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got en=%b busy=%b done=%b addr=%h data=%h, expected all 0",
                     write_en, busy, done, write_address, write_data);
        end
        rst = 1'b1;
        for (int k = 0; k < I; k++) vector_data[k*L +: L] = L'(k + 1);
        drive_start(1'b1, 10'h100, 10'h001, CW'(10));
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (write_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_preload: got en=%b busy=%b, expected en=1 busy=1", write_en, busy);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({write_en, busy, done, write_address, write_data} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_async: got en=%b busy=%b done=%b addr=%h data=%h, expected all 0",
                     write_en, busy, done, write_address, write_data);
        end
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (write_en || done || busy) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_abandon: got %0d active cycles after reset, expected 0", bad);
        end
    endtask

    task automatic test_scalar();
        int dc, en;
        logic [A-1:0] ea, oa;
        logic [L-1:0] ed, od;
        scalar_data = 32'hDEADBEEF;
        exp_addr.push_back(10'h040);
        exp_data.push_back(32'hDEADBEEF);
        drive_start(1'b0, 10'h040, 10'h009, CW'(7));
        collect(10, 0, -1, 1'b0, 1'b0, dc, en);
        n_checks++;
        if (dc != 2 || en != 1) begin
            n_fail++;
            $display("[TB] FAIL scalar_timing: got done cycle %0d, %0d write cycles, expected 2 and 1", dc, en);
        end
        while (exp_addr.size() > 0) begin
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            n_checks++;
            if (obs_addr.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL scalar_write: got no write, expected addr %h data %h", ea, ed);
            end else begin
                oa = obs_addr.pop_front();
                od = obs_data.pop_front();
                if (oa !== ea || od !== ed) begin
                    n_fail++;
                    $display("[TB] FAIL scalar_write: got addr %h data %h, expected addr %h data %h", oa, od, ea, ed);
                end
            end
        end
        n_checks++;
        if (obs_addr.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scalar_extra: got %0d extra writes, expected 0", obs_addr.size());
            obs_addr.delete();
            obs_data.delete();
        end
    endtask

    task automatic test_vector_stride();
        int dc, en;
        logic [A-1:0] ea, oa;
        logic [L-1:0] ed, od;
        for (int k = 0; k < I; k++) vector_data[k*L +: L] = L'(k + 32'h10);
        for (int k = 0; k < 5; k++) begin
            exp_addr.push_back(A'(10'h100 + 2 * k));
            exp_data.push_back(L'(k + 32'h10));
        end
        drive_start(1'b1, 10'h100, 10'h002, CW'(5));
        collect(12, 0, -1, 1'b0, 1'b0, dc, en);
        n_checks++;
        if (dc != 6 || en != 5) begin
            n_fail++;
            $display("[TB] FAIL stride_timing: got done cycle %0d, %0d write cycles, expected 6 and 5", dc, en);
        end
        while (exp_addr.size() > 0) begin
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            n_checks++;
            if (obs_addr.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL stride_write: got no write, expected addr %h data %h", ea, ed);
            end else begin
                oa = obs_addr.pop_front();
                od = obs_data.pop_front();
                if (oa !== ea || od !== ed) begin
                    n_fail++;
                    $display("[TB] FAIL stride_write: got addr %h data %h, expected addr %h data %h", oa, od, ea, ed);
                end
            end
        end
        n_checks++;
        if (obs_addr.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL stride_extra: got %0d extra writes, expected 0", obs_addr.size());
            obs_addr.delete();
            obs_data.delete();
        end
    endtask

    task automatic test_stall_wrap();
        int dc, en;
        logic [A-1:0] ea, oa;
        logic [L-1:0] ed, od;
        logic [A-1:0] addrs[4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        for (int k = 0; k < I; k++) vector_data[k*L +: L] = L'(k + 32'hA0);
        for (int k = 0; k < 4; k++) begin
            exp_addr.push_back(addrs[k]);
            exp_data.push_back(L'(k + 32'hA0));
        end
        drive_start(1'b1, 10'h3FE, 10'h001, CW'(4));
        collect(15, 2, 3, 1'b0, 1'b0, dc, en);
        n_checks++;
        if (dc != 7 || en != 6) begin
            n_fail++;
            $display("[TB] FAIL stall_timing: got done cycle %0d, %0d write cycles, expected 7 and 6", dc, en);
        end
        while (exp_addr.size() > 0) begin
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            n_checks++;
            if (obs_addr.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL stall_write: got no write, expected addr %h data %h", ea, ed);
            end else begin
                oa = obs_addr.pop_front();
                od = obs_data.pop_front();
                if (oa !== ea || od !== ed) begin
                    n_fail++;
                    $display("[TB] FAIL stall_write: got addr %h data %h, expected addr %h data %h", oa, od, ea, ed);
                end
            end
        end
        n_checks++;
        if (obs_addr.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL stall_extra: got %0d extra writes, expected 0", obs_addr.size());
            obs_addr.delete();
            obs_data.delete();
        end
    endtask

    task automatic test_bounds();
        int dc, en;
        logic [A-1:0] ea, oa;
        logic [L-1:0] ed, od;
        drive_start(1'b1, 10'h050, 10'h001, CW'(0));
        collect(6, 0, -1, 1'b0, 1'b0, dc, en);
        n_checks++;
        if (dc != 1 || en != 0 || obs_addr.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL vlen_zero: got done cycle %0d, %0d write cycles, expected 1 and 0", dc, en);
            obs_addr.delete();
            obs_data.delete();
        end
        for (int k = 0; k < I; k++) begin
            vector_data[k*L +: L] = $urandom;
            exp_addr.push_back(A'(3 * k));
            exp_data.push_back(vector_data[k*L +: L]);
        end
        drive_start(1'b1, 10'h000, 10'h003, CW'(25));
        collect(40, 0, -1, 1'b0, 1'b0, dc, en);
        n_checks++;
        if (dc != I + 1 || en != I) begin
            n_fail++;
            $display("[TB] FAIL vlen_clamp: got done cycle %0d, %0d write cycles, expected %0d and %0d", dc, en, I + 1, I);
        end
        while (exp_addr.size() > 0) begin
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            n_checks++;
            if (obs_addr.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL clamp_write: got no write, expected addr %h data %h", ea, ed);
            end else begin
                oa = obs_addr.pop_front();
                od = obs_data.pop_front();
                if (oa !== ea || od !== ed) begin
                    n_fail++;
                    $display("[TB] FAIL clamp_write: got addr %h data %h, expected addr %h data %h", oa, od, ea, ed);
                end
            end
        end
        n_checks++;
        if (obs_addr.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL clamp_extra: got %0d extra writes, expected 0", obs_addr.size());
            obs_addr.delete();
            obs_data.delete();
        end
    endtask

    // Start stays high and operands churn while busy; the next start lands at cycle count+2.
    task automatic test_back_to_back();
        int dc, en;
        logic [A-1:0] ea, oa;
        logic [L-1:0] ed, od;
        for (int k = 0; k < I; k++) vector_data[k*L +: L] = L'(32'h5500 + k);
        for (int k = 0; k < 3; k++) begin
            exp_addr.push_back(A'(10'h200 + k));
            exp_data.push_back(L'(32'h5500 + k));
        end
        drive_start(1'b1, 10'h200, 10'h001, CW'(3));
        collect(10, 0, -1, 1'b1, 1'b1, dc, en);
        n_checks++;
        if (dc != 4 || en != 3) begin
            n_fail++;
            $display("[TB] FAIL busy_start: got done cycle %0d, %0d write cycles, expected 4 and 3", dc, en);
        end
        scalar_data = 32'hCAFE0123;
        exp_addr.push_back(10'h0AA);
        exp_data.push_back(32'hCAFE0123);
        drive_start(1'b0, 10'h0AA, 10'h000, CW'(0));
        collect(10, 0, -1, 1'b0, 1'b0, dc, en);
        n_checks++;
        if (dc != 2 || en != 1) begin
            n_fail++;
            $display("[TB] FAIL next_start: got done cycle %0d, %0d write cycles, expected 2 and 1", dc, en);
        end
        while (exp_addr.size() > 0) begin
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            n_checks++;
            if (obs_addr.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL b2b_write: got no write, expected addr %h data %h", ea, ed);
            end else begin
                oa = obs_addr.pop_front();
                od = obs_data.pop_front();
                if (oa !== ea || od !== ed) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_write: got addr %h data %h, expected addr %h data %h", oa, od, ea, ed);
                end
            end
        end
        n_checks++;
        if (obs_addr.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_extra: got %0d extra writes, expected 0", obs_addr.size());
            obs_addr.delete();
            obs_data.delete();
        end
    endtask

`ifdef VWS_MASK_EN
    task automatic test_mask();
        int dc, en;
        logic [A-1:0] ea, oa;
        logic [L-1:0] ed, od;
        for (int k = 0; k < I; k++) vector_data[k*L +: L] = L'(32'h700 + k);
        mask = I'(4'b1010);
        exp_addr.push_back(10'h004);
        exp_data.push_back(32'h701);
        exp_addr.push_back(10'h00C);
        exp_data.push_back(32'h703);
        drive_start(1'b1, 10'h000, 10'h004, CW'(4));
        collect(10, 0, -1, 1'b0, 1'b0, dc, en);
        mask = '1;
        n_checks++;
        if (dc != 5 || en != 2) begin
            n_fail++;
            $display("[TB] FAIL mask_timing: got done cycle %0d, %0d write cycles, expected 5 and 2", dc, en);
        end
        while (exp_addr.size() > 0) begin
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            n_checks++;
            if (obs_addr.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL mask_write: got no write, expected addr %h data %h", ea, ed);
            end else begin
                oa = obs_addr.pop_front();
                od = obs_data.pop_front();
                if (oa !== ea || od !== ed) begin
                    n_fail++;
                    $display("[TB] FAIL mask_write: got addr %h data %h, expected addr %h data %h", oa, od, ea, ed);
                end
            end
        end
        n_checks++;
        if (obs_addr.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL mask_extra: got %0d extra writes, expected 0", obs_addr.size());
            obs_addr.delete();
            obs_data.delete();
        end
    endtask
`endif

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        op_type      = 1'b0;
        vector_data  = '0;
        scalar_data  = '0;
        base_address = '0;
        stride       = '0;
        vlen         = '0;
        mem_ready    = 1'b1;
`ifdef VWS_MASK_EN
        mask         = '1;
`endif
        $display("[TB] vector_write_sequencer bench starting");
        test_reset();
        test_scalar();
        test_vector_stride();
        test_stall_wrap();
        test_bounds();
        test_back_to_back();
`ifdef VWS_MASK_EN
        test_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_write_sequencer.md
Name: vector_write_sequencer

Overview:
- Parametrised write-back sequencer between the vector execution unit and data memory.
- Issues one scalar store, or a strided vector store of programmable length.
- Uses a start/busy/done handshake and stalls on memory back-pressure (mem_ready).
- Operands are captured on start, so the register file may change while the block writes.

Parameters:
- I, 20, maximum number of vector items.
- L, 32, item width in bits.
- A, 10, address width in bits.
- CW, $clog2(I+1), width of the vlen and item-index fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low; asserting 0 resets immediately.
- start  in  1  request pulse; sampled only in IDLE.
- op_type  in  1  1 = vector store, 0 = scalar store.
- vector_data  in  I*L  packed items; item k is at bits [k*L +: L].
- scalar_data  in  L  scalar store value.
- base_address  in  A  first write address.
- stride  in  A  address increment between vector items, unsigned.
- vlen  in  CW  number of vector items to write.
- mem_ready  in  1  memory accepts the current write this cycle.
- write_en  out  1  write request valid.
- write_address  out  A  write address.
- write_data  out  L  write data.
- busy  out  1  high while in WRITE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- FSM states: IDLE, WRITE, DONE. State, index, captured operands and the address accumulator are registers. Outputs decode combinationally from registers only, with no input-to-output paths except the mem_ready stall.
- Reset (rst=0, at any time including mid-operation):
  - state=IDLE, index=0, captured registers=0.
  - write_en=0, write_address=0, write_data=0, busy=0, done=0.
  - Any in-flight store is abandoned with no done pulse.
- IDLE, start=1 at an edge:
  - Capture op_type, vector_data, scalar_data, base_address, stride.
  - Compute count = 1 if scalar; otherwise min(vlen, I).
  - If count=0, go to DONE; else go to WRITE with index=0 and addr=base_address.
- WRITE:
  - write_en=1, busy=1, write_address=addr.
  - write_data = captured scalar (scalar op) or item[index] (vector op).
  - A write is accepted when write_en and mem_ready are both 1. On acceptance: index+1, addr = addr + stride, modulo 2^A (wraps silently).
  - mem_ready=0: hold index, address and data stable; no advance.
  - Acceptance with index = count-1: go to DONE.
- DONE: done=1, busy=0, write_en=0 for exactly one cycle, then IDLE.
- start in WRITE or DONE is ignored (not queued).
- Latency, mem_ready held high, start sampled at edge 0:
  - Writes occupy cycles 1..count.
  - done is high in cycle count+1.
  - The next start is accepted at the edge ending cycle count+2 (IDLE) or later.
- vlen > I is clamped to I with no error. vlen=0 vector: no writes, done in cycle 1.
- The scalar path ignores vlen and stride.

Optional Feature:
- Macro: VWS_MASK_EN.
- Defined:
  - Adds input mask, width I, captured on start.
  - Item k with mask[k]=0 still takes one WRITE cycle, with write_en=0.
  - The index and address advance regardless of mem_ready, so addresses remain base+k*stride.
  - The scalar path ignores mask.
- Undefined: no mask port; every item below count is written.

Test Plan:
- Reset: drive rst=0 mid-vector-store, then release → all outputs 0, state IDLE, no done pulse; next start behaves normally.
- Scalar: start, op_type=0, base=0x040, scalar=0xDEADBEEF, mem_ready=1 → one write (0x040, 0xDEADBEEF) in cycle 1, done in cycle 2.
- Vector stride: op_type=1, base=0x100, stride=2, vlen=5, item k = k+0x10 → writes (0x100,0x10), (0x102,0x11) … (0x108,0x14), done in cycle 6.
- Stall and wrap: base=0x3FE, stride=1, vlen=4, mem_ready low in cycles 2–3 → addresses 0x3FE, 0x3FF (held for 3 cycles), 0x000, 0x001; done in cycle 7.
- Bounds: vlen=0 → done in cycle 1 with no write_en. vlen=25 with I=20 → exactly 20 writes. start asserted while busy → ignored.
- VWS_MASK_EN: vlen=4, mask=4'b1010, base=0, stride=4 → writes only at 0x004 and 0x00C; done in cycle 5.
